// File: rtl/vx_tma_requester_pkg.sv
// Shared TMA bus definitions: widths, op encodings and the response layout
// used by both the core-side requester and the cluster TMA engines.
package vx_tma_requester_pkg;

    localparam int XLEN       = 32;
    localparam int UUID_WIDTH = 8;
    localparam int NUM_WARPS  = 4;
    localparam int NW_WIDTH   = 2;
    localparam int NUM_CORES  = 4;
    localparam int NC_WIDTH   = 2;
    localparam int BAR_ADDR_W = 4;

    localparam logic [2:0] TMA_OP_DESC_LO  = 3'd0;
    localparam logic [2:0] TMA_OP_DESC_HI  = 3'd1;
    localparam logic [2:0] TMA_OP_COORD_LO = 3'd2;
    localparam logic [2:0] TMA_OP_COORD_HI = 3'd3;
    localparam logic [2:0] TMA_OP_ISSUE    = 3'd4;

    typedef struct packed {
        logic [NC_WIDTH-1:0]   core_id;
        logic [UUID_WIDTH-1:0] uuid;
        logic [NW_WIDTH-1:0]   wid;
        logic [2:0]            op;
        logic [XLEN-1:0]       rs1;
        logic [XLEN-1:0]       rs2;
    } tma_req_t;

    typedef struct packed {
        logic [NC_WIDTH-1:0]   core_id;
        logic [UUID_WIDTH-1:0] uuid;
        logic [NW_WIDTH-1:0]   wid;
        logic [BAR_ADDR_W-1:0] bar_addr;
        logic                  err;
        logic                  done;
    } tma_rsp_t;

    localparam int TMA_REQ_DATAW = $bits(tma_req_t);
    localparam int TMA_RSP_DATAW = $bits(tma_rsp_t);

    function automatic logic is_issue(input logic [2:0] op);
        return op == TMA_OP_ISSUE;
    endfunction

endpackage

// File: rtl/vx_tma_requester_if.sv
// TMA bus between a core-side requester (master) and a TMA engine (slave).
// Both channels: a transfer happens on a clock edge where valid && ready;
// valid must not depend on ready, and data is held while valid && !ready.
interface vx_tma_requester_if;
    import vx_tma_requester_pkg::*;

    logic                     req_valid;
    logic                     req_ready;
    logic [TMA_REQ_DATAW-1:0] req_data;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [TMA_RSP_DATAW-1:0] rsp_data;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        output rsp_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        input  rsp_ready
    );

endinterface

// File: rtl/vx_tma_requester_pending_ctr.sv
// Per-warp outstanding-transfer counters with saturation and underflow
// lookups for the warp being admitted and the warp being retired.
module vx_tma_requester_pending_ctr
    import vx_tma_requester_pkg::*;
#(
    parameter int MAX_PENDING = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 inc_i,
    input  logic [NW_WIDTH-1:0]  inc_wid_i,
    input  logic                 dec_i,
    input  logic [NW_WIDTH-1:0]  dec_wid_i,
    output logic                 inc_sat_o,
    output logic                 dec_empty_o,
    output logic [NUM_WARPS-1:0] pending_o
);

    localparam int            CW      = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING);

    logic [CW-1:0]        cnt_q [NUM_WARPS];
    logic [CW-1:0]        cnt_d [NUM_WARPS];
    logic [NUM_WARPS-1:0] up;
    logic [NUM_WARPS-1:0] dn;

    assign up = inc_i ? (NUM_WARPS'(1) << inc_wid_i) : '0;
    assign dn = dec_i ? (NUM_WARPS'(1) << dec_wid_i) : '0;

    // Simultaneous inc and dec on one warp cancel out.
    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            cnt_d[w] = cnt_q[w];
            case ({up[w], dn[w]})
                2'b10:   cnt_d[w] = cnt_q[w] + CW'(1);
                2'b01:   cnt_d[w] = cnt_q[w] - CW'(1);
                default: cnt_d[w] = cnt_q[w];
            endcase
        end
    end

    always_comb begin
        for (int w = 0; w < NUM_WARPS; w++) begin
            pending_o[w] = (cnt_q[w] != '0);
        end
    end

    assign inc_sat_o   = (cnt_q[inc_wid_i] == CNT_MAX);
    assign dec_empty_o = (cnt_q[dec_wid_i] == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                cnt_q[w] <= cnt_d[w];
            end
        end
    end

endmodule

// File: rtl/vx_tma_requester.sv
// Core-side TMA initiator: packs execute-path TMA ops into bus requests,
// tracks outstanding ISSUEs per warp and turns completions into barrier arrives.
module vx_tma_requester
    import vx_tma_requester_pkg::*;
#(
    parameter int CORE_ID      = 0,
    parameter int MAX_PENDING  = 4,
    parameter int REQ_BUF_SIZE = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,

    input  logic                   exe_valid_i,
    output logic                   exe_ready_o,
    input  logic [UUID_WIDTH-1:0]  exe_uuid_i,
    input  logic [NW_WIDTH-1:0]    exe_wid_i,
    input  logic [2:0]             exe_op_i,
    input  logic [XLEN-1:0]        exe_rs1_i,
    input  logic [XLEN-1:0]        exe_rs2_i,

    vx_tma_requester_if.master     tma_bus_if,

    output logic                   bar_valid_o,
    input  logic                   bar_ready_i,
    output logic [NW_WIDTH-1:0]    bar_wid_o,
    output logic [BAR_ADDR_W-1:0]  bar_addr_o,
    output logic                   bar_error_o,

    output logic [NUM_WARPS-1:0]   warp_pending_o,
    output logic                   err_sticky_o
);

    localparam int PW  = (REQ_BUF_SIZE > 1) ? $clog2(REQ_BUF_SIZE) : 1;
    localparam int BCW = $clog2(REQ_BUF_SIZE + 1);

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(REQ_BUF_SIZE - 1)) ? '0 : p + PW'(1);
    endfunction

    // ---------------- request path: elastic buffer ----------------
    tma_req_t         req_pack;
    logic [TMA_REQ_DATAW-1:0] buf_q [REQ_BUF_SIZE];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [BCW-1:0]   count_q, count_d;
    logic             buf_ready;
    logic             push;
    logic             pop;
    logic             ctr_sat;
    logic             ctr_empty;

    assign req_pack = '{core_id: NC_WIDTH'(CORE_ID), uuid: exe_uuid_i, wid: exe_wid_i,
                        op: exe_op_i, rs1: exe_rs1_i, rs2: exe_rs2_i};

    // Admission never looks at req_ready or the response channel, so there is
    // no combinational path from the bus back to exe_ready.
    assign buf_ready   = (count_q != BCW'(REQ_BUF_SIZE));
    assign exe_ready_o = buf_ready && !(is_issue(exe_op_i) && ctr_sat);
    assign push        = exe_valid_i && exe_ready_o;
    assign pop         = tma_bus_if.req_valid && tma_bus_if.req_ready;

    assign tma_bus_if.req_valid = (count_q != '0);
    assign tma_bus_if.req_data  = buf_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + BCW'(1);
            2'b01:   count_d = count_q - BCW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < REQ_BUF_SIZE; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) begin
                buf_q[wr_ptr_q] <= req_pack;
            end
        end
    end

    // ---------------- response path ----------------
    tma_rsp_t               rsp;
    logic                   rsp_fire;
    logic                   core_bad;
    logic                   rsp_accept;
    logic                   bar_load;
    logic                   rsp_unused;
    logic                   bar_valid_q, bar_valid_d;
    logic [NW_WIDTH-1:0]    bar_wid_q, bar_wid_d;
    logic [BAR_ADDR_W-1:0]  bar_addr_q, bar_addr_d;
    logic                   bar_err_q, bar_err_d;
    logic                   err_sticky_q, err_sticky_d;

    assign rsp        = tma_rsp_t'(tma_bus_if.rsp_data);
    assign rsp_unused = ^rsp.uuid;

    assign tma_bus_if.rsp_ready = !bar_valid_q || bar_ready_i;
    assign rsp_fire   = tma_bus_if.rsp_valid && tma_bus_if.rsp_ready;
    assign core_bad   = (rsp.core_id != NC_WIDTH'(CORE_ID));
    // Foreign or unmatched responses are dropped without touching any counter.
    assign rsp_accept = rsp_fire && !core_bad && !ctr_empty;
    assign bar_load   = rsp_accept && rsp.done;

    vx_tma_requester_pending_ctr #(
        .MAX_PENDING (MAX_PENDING)
    ) u_pending_ctr (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .inc_i       (push && is_issue(exe_op_i)),
        .inc_wid_i   (exe_wid_i),
        .dec_i       (rsp_accept),
        .dec_wid_i   (rsp.wid),
        .inc_sat_o   (ctr_sat),
        .dec_empty_o (ctr_empty),
        .pending_o   (warp_pending_o)
    );

    always_comb begin
        bar_valid_d  = bar_valid_q;
        bar_wid_d    = bar_wid_q;
        bar_addr_d   = bar_addr_q;
        bar_err_d    = bar_err_q;
        err_sticky_d = err_sticky_q | (rsp_fire && (core_bad || ctr_empty));
        if (bar_ready_i) begin
            bar_valid_d = 1'b0;
        end
        if (bar_load) begin
            bar_valid_d = 1'b1;
            bar_wid_d   = rsp.wid;
            bar_addr_d  = rsp.bar_addr;
            bar_err_d   = rsp.err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bar_valid_q  <= 1'b0;
            bar_wid_q    <= '0;
            bar_addr_q   <= '0;
            bar_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            bar_valid_q  <= bar_valid_d;
            bar_wid_q    <= bar_wid_d;
            bar_addr_q   <= bar_addr_d;
            bar_err_q    <= bar_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign bar_valid_o  = bar_valid_q;
    assign bar_wid_o    = bar_wid_q;
    assign bar_addr_o   = bar_addr_q;
    assign bar_error_o  = bar_err_q;
    assign err_sticky_o = err_sticky_q;

endmodule

// File: tb/tb_vx_tma_requester.sv
// Directed bench for vx_tma_requester: request packing table, saturation,
// same-cycle inc/dec, barrier backpressure, dropped responses and async reset.
module tb_vx_tma_requester;
    import vx_tma_requester_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic                  exe_valid;
    logic                  exe_ready;
    logic [UUID_WIDTH-1:0] exe_uuid;
    logic [NW_WIDTH-1:0]   exe_wid;
    logic [2:0]            exe_op;
    logic [XLEN-1:0]       exe_rs1;
    logic [XLEN-1:0]       exe_rs2;
    logic                  bar_valid;
    logic                  bar_ready;
    logic [NW_WIDTH-1:0]   bar_wid;
    logic [BAR_ADDR_W-1:0] bar_addr;
    logic                  bar_error;
    logic [NUM_WARPS-1:0]  warp_pending;
    logic                  err_sticky;

    vx_tma_requester_if bus ();

    vx_tma_requester #(
        .CORE_ID      (0),
        .MAX_PENDING  (4),
        .REQ_BUF_SIZE (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .exe_valid_i    (exe_valid),
        .exe_ready_o    (exe_ready),
        .exe_uuid_i     (exe_uuid),
        .exe_wid_i      (exe_wid),
        .exe_op_i       (exe_op),
        .exe_rs1_i      (exe_rs1),
        .exe_rs2_i      (exe_rs2),
        .tma_bus_if     (bus),
        .bar_valid_o    (bar_valid),
        .bar_ready_i    (bar_ready),
        .bar_wid_o      (bar_wid),
        .bar_addr_o     (bar_addr),
        .bar_error_o    (bar_error),
        .warp_pending_o (warp_pending),
        .err_sticky_o   (err_sticky)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [TMA_REQ_DATAW-1:0]        req_q [$];
    logic [NW_WIDTH+BAR_ADDR_W:0]    exp_q [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.req_valid && bus.req_ready) begin
                if (req_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL req_unexpected: got 0x%0h, expected no request", bus.req_data);
                end else begin
                    check("req_order", bus.req_data, req_q.pop_front());
                end
            end
            if (bar_valid && bar_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL bar_unexpected: got wid=%0d addr=%0h err=%0b, expected no event",
                             bar_wid, bar_addr, bar_error);
                end else begin
                    check("bar_event", {bar_wid, bar_addr, bar_error}, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] wid, input logic [2:0] op, input logic [7:0] uuid,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        int waited = 0;
        exe_valid = 1'b1;
        exe_wid   = wid;
        exe_op    = op;
        exe_uuid  = uuid;
        exe_rs1   = rs1;
        exe_rs2   = rs2;
        #1;
        while (!exe_ready && waited < 20) begin
            tick();
            #1;
            waited++;
        end
        if (!exe_ready) begin
            n_checks++;
            $display("FAIL issue_timeout: got exe_ready=0 for 20 cycles, expected 1");
            exe_valid = 1'b0;
            tick();
        end else begin
            req_q.push_back({2'b00, uuid, wid, op, rs1, rs2});
            tick();
            exe_valid = 1'b0;
        end
    endtask

    task automatic send_rsp(input logic [1:0] core, input logic [7:0] uuid, input logic [1:0] wid,
                            input logic [3:0] addr, input logic err, input logic done,
                            input logic expect_evt);
        int waited = 0;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = {core, uuid, wid, addr, err, done};
        #1;
        while (!bus.rsp_ready && waited < 20) begin
            tick();
            #1;
            waited++;
        end
        if (!bus.rsp_ready) begin
            n_checks++;
            $display("FAIL rsp_timeout: got rsp_ready=0 for 20 cycles, expected 1");
        end else if (expect_evt) begin
            exp_q.push_back({wid, addr, err});
        end
        tick();
        bus.rsp_valid = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  wid;
        logic [2:0]  op;
        logic [7:0]  uuid;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  exp_pend;
    } vec_t;

    vec_t vecs [4];

    initial begin
        vecs[0] = '{2'd2, 3'd4, 8'h11, 32'hA000_0000, 32'h0003_0001, 4'b0100};
        vecs[1] = '{2'd1, 3'd1, 8'h22, 32'h1234_5678, 32'hDEAD_BEEF, 4'b0100};
        vecs[2] = '{2'd3, 3'd4, 8'h33, 32'hFFFF_FFFF, 32'h0000_0000, 4'b1100};
        vecs[3] = '{2'd0, 3'd0, 8'hFF, 32'h0000_0000, 32'h8000_0001, 4'b1100};

        rst_n         = 1'b0;
        exe_valid     = 1'b0;
        exe_uuid      = '0;
        exe_wid       = '0;
        exe_op        = '0;
        exe_rs1       = '0;
        exe_rs2       = '0;
        bar_ready     = 1'b1;
        bus.req_ready = 1'b1;
        bus.rsp_valid = 1'b0;
        bus.rsp_data  = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        check("reset_req_valid", bus.req_valid, 1'b0);
        check("reset_warp_pending", warp_pending, 4'b0000);
        check("reset_bar_valid", bar_valid, 1'b0);
        check("reset_err_sticky", err_sticky, 1'b0);
        check("reset_exe_ready", exe_ready, 1'b1);
        check("reset_rsp_ready", bus.rsp_ready, 1'b1);

        // Packing and 1-cycle request latency.
        for (int i = 0; i < 4; i++) begin
            issue(vecs[i].wid, vecs[i].op, vecs[i].uuid, vecs[i].rs1, vecs[i].rs2);
            #1;
            check("vec_req_valid", bus.req_valid, 1'b1);
            check("vec_core_id", bus.req_data[78:77], 2'd0);
            check("vec_uuid", bus.req_data[76:69], vecs[i].uuid);
            check("vec_wid", bus.req_data[68:67], vecs[i].wid);
            check("vec_op", bus.req_data[66:64], vecs[i].op);
            check("vec_rs1", bus.req_data[63:32], vecs[i].rs1);
            check("vec_rs2", bus.req_data[31:0], vecs[i].rs2);
            check("vec_pending", warp_pending, vecs[i].exp_pend);
            tick();
        end
        check("vec_buf_drained", bus.req_valid, 1'b0);

        send_rsp(2'd0, 8'h11, 2'd2, 4'h5, 1'b0, 1'b1, 1'b1);
        #1;
        check("rsp1_bar_valid", bar_valid, 1'b1);
        check("rsp1_bar_wid", bar_wid, 2'd2);
        check("rsp1_bar_addr", bar_addr, 4'h5);
        check("rsp1_bar_error", bar_error, 1'b0);
        check("rsp1_pending", warp_pending, 4'b1000);
        tick();
        check("rsp1_bar_cleared", bar_valid, 1'b0);
        send_rsp(2'd0, 8'h33, 2'd3, 4'h9, 1'b1, 1'b1, 1'b1);
        #1;
        check("rsp2_bar_error", bar_error, 1'b1);
        check("rsp2_pending", warp_pending, 4'b0000);
        tick();

        // Saturation of warp 0 at MAX_PENDING.
        for (int k = 0; k < 4; k++) begin
            issue(2'd0, 3'd4, 8'h40 + 8'(k), 32'(k), 32'(k));
        end
        exe_valid = 1'b1; exe_op = 3'd4; exe_wid = 2'd0; exe_uuid = 8'h44;
        exe_rs1 = 32'h44; exe_rs2 = 32'h44;
        #1;
        check("sat_exe_ready", exe_ready, 1'b0);
        check("sat_pending", warp_pending, 4'b0001);
        tick();
        check("sat_exe_ready_hold", exe_ready, 1'b0);
        exe_op = 3'd1; exe_uuid = 8'h45;
        #1;
        check("sat_setup_exe_ready", exe_ready, 1'b1);
        req_q.push_back({2'b00, 8'h45, 2'd0, 3'd1, 32'h44, 32'h44});
        tick();
        exe_op = 3'd4; exe_uuid = 8'h44;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = {2'd0, 8'h40, 2'd0, 4'h1, 1'b0, 1'b1};
        exp_q.push_back({2'd0, 4'h1, 1'b0});
        #1;
        check("sat_same_cycle_exe_ready", exe_ready, 1'b0);
        check("sat_rsp_ready", bus.rsp_ready, 1'b1);
        tick();
        bus.rsp_valid = 1'b0;
        #1;
        check("sat_readmit_exe_ready", exe_ready, 1'b1);
        req_q.push_back({2'b00, 8'h44, 2'd0, 3'd4, 32'h44, 32'h44});
        tick();
        exe_valid = 1'b0;

        // Same warp, same cycle inc and dec at cnt=2.
        send_rsp(2'd0, 8'h41, 2'd0, 4'h2, 1'b0, 1'b1, 1'b1);
        send_rsp(2'd0, 8'h42, 2'd0, 4'h3, 1'b0, 1'b1, 1'b1);
        exe_valid = 1'b1; exe_op = 3'd4; exe_wid = 2'd0; exe_uuid = 8'h46;
        exe_rs1 = 32'h46; exe_rs2 = 32'h46;
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = {2'd0, 8'h43, 2'd0, 4'h7, 1'b0, 1'b1};
        #1;
        check("same_exe_ready", exe_ready, 1'b1);
        check("same_rsp_ready", bus.rsp_ready, 1'b1);
        req_q.push_back({2'b00, 8'h46, 2'd0, 3'd4, 32'h46, 32'h46});
        exp_q.push_back({2'd0, 4'h7, 1'b0});
        tick();
        exe_valid = 1'b0;
        bus.rsp_valid = 1'b0;
        #1;
        check("same_pending", warp_pending, 4'b0001);
        check("same_bar_valid", bar_valid, 1'b1);
        tick();
        send_rsp(2'd0, 8'h44, 2'd0, 4'h8, 1'b0, 1'b1, 1'b1);
        #1;
        check("same_cnt_after1", warp_pending, 4'b0001);
        send_rsp(2'd0, 8'h46, 2'd0, 4'h9, 1'b0, 1'b1, 1'b1);
        #1;
        check("same_cnt_after2", warp_pending, 4'b0000);
        tick();

        // Barrier backpressure with three queued responses.
        for (int k = 0; k < 3; k++) begin
            issue(2'd1, 3'd4, 8'h50 + 8'(k), 32'h0, 32'h0);
        end
        bar_ready = 1'b0;
        send_rsp(2'd0, 8'h50, 2'd1, 4'hA, 1'b0, 1'b1, 1'b1);
        #1;
        check("bp_bar_valid", bar_valid, 1'b1);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = {2'd0, 8'h51, 2'd1, 4'hB, 1'b0, 1'b1};
        exp_q.push_back({2'd1, 4'hB, 1'b0});
        for (int c = 0; c < 5; c++) begin
            check("bp_rsp_ready_low", bus.rsp_ready, 1'b0);
            check("bp_bar_addr_stable", bar_addr, 4'hA);
            tick();
            #1;
        end
        bar_ready = 1'b1;
        #1;
        check("bp_release_rsp_ready", bus.rsp_ready, 1'b1);
        tick();
        bus.rsp_data = {2'd0, 8'h52, 2'd1, 4'hC, 1'b0, 1'b1};
        exp_q.push_back({2'd1, 4'hC, 1'b0});
        #1;
        check("bp_nobubble_rsp_ready", bus.rsp_ready, 1'b1);
        check("bp_second_addr", bar_addr, 4'hB);
        tick();
        bus.rsp_valid = 1'b0;
        #1;
        check("bp_third_addr", bar_addr, 4'hC);
        check("bp_pending", warp_pending, 4'b0000);
        tick();

        // Dropped and aborted responses.
        issue(2'd2, 3'd4, 8'h60, 32'h0, 32'h0);
        send_rsp(2'd0, 8'h61, 2'd3, 4'h2, 1'b0, 1'b1, 1'b0);
        #1;
        check("uf_err_sticky", err_sticky, 1'b1);
        check("uf_bar_valid", bar_valid, 1'b0);
        check("uf_pending", warp_pending, 4'b0100);
        send_rsp(2'd1, 8'h60, 2'd2, 4'h3, 1'b0, 1'b1, 1'b0);
        #1;
        check("core_bar_valid", bar_valid, 1'b0);
        check("core_pending", warp_pending, 4'b0100);
        check("core_err_sticky", err_sticky, 1'b1);
        send_rsp(2'd0, 8'h60, 2'd2, 4'h4, 1'b0, 1'b0, 1'b0);
        #1;
        check("abort_bar_valid", bar_valid, 1'b0);
        check("abort_pending", warp_pending, 4'b0000);
        tick();

        // Asynchronous reset mid-burst.
        for (int k = 0; k < 4; k++) begin
            issue(2'd1, 3'd4, 8'h70 + 8'(k), 32'h0, 32'h0);
        end
        bar_ready = 1'b0;
        send_rsp(2'd0, 8'h70, 2'd1, 4'h5, 1'b0, 1'b1, 1'b0);
        bus.req_ready = 1'b0;
        issue(2'd1, 3'd1, 8'h74, 32'h1, 32'h2);
        #1;
        check("pre_rst_bar_valid", bar_valid, 1'b1);
        check("pre_rst_req_valid", bus.req_valid, 1'b1);
        check("pre_rst_pending", warp_pending, 4'b0010);
        #1;
        rst_n = 1'b0;
        req_q.delete();
        #1;
        check("rst_req_valid", bus.req_valid, 1'b0);
        check("rst_bar_valid", bar_valid, 1'b0);
        check("rst_pending", warp_pending, 4'b0000);
        check("rst_err_sticky", err_sticky, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        bus.req_ready = 1'b1;
        bar_ready = 1'b1;
        tick();
        send_rsp(2'd0, 8'h71, 2'd1, 4'h6, 1'b0, 1'b1, 1'b0);
        #1;
        check("stale_err_sticky", err_sticky, 1'b1);
        check("stale_bar_valid", bar_valid, 1'b0);
        issue(2'd1, 3'd4, 8'h80, 32'h8, 32'h9);
        #1;
        check("resume_pending", warp_pending, 4'b0010);
        check("resume_req_valid", bus.req_valid, 1'b1);
        send_rsp(2'd0, 8'h80, 2'd1, 4'hE, 1'b0, 1'b1, 1'b1);
        #1;
        check("resume_bar_valid", bar_valid, 1'b1);
        check("resume_pending_clear", warp_pending, 4'b0000);
        repeat (3) tick();

        check("end_exp_q_empty", exp_q.size(), 0);
        check("end_req_q_empty", req_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
